instr_fetch: RTL
================

Name: instr_fetch

Overview:
- Instruction fetch stage directly upstream of instr_decoder.
- Holds the program counter (PC) and requests 11-bit instruction words from program memory over a chip-select/valid handshake.
- Latches each returned word into an instruction register and presents it to the decoder as opcode / mem_addr / imm_val.
- Supports stall from downstream, a one-shot jump, and a halt opcode that freezes fetching.

Parameters:
- PC_W, 4, width of the PC and of imem_addr / jmp_addr.
- HALT_OP, 3'b111, opcode value that stops fetching after it is issued.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rstn  input  1  asynchronous active-low reset
- run  input  1  level enable; fetching proceeds while high
- imem_addr  output  PC_W  program memory address, equals pc
- imem_csn  output  1  program memory chip select, active low
- imem_data  input  11  instruction word: [10:8] opcode, [7:4] mem_addr, [3:0] imm_val
- imem_valid  input  1  memory data valid; sampled only in WAIT
- stall  input  1  downstream not ready; holds the current instruction
- jmp_en  input  1  take jump at the end of the current ISSUE
- jmp_addr  input  PC_W  jump target
- opcode  output  3  to decoder
- mem_addr  output  4  to decoder
- imm_val  output  4  to decoder
- instr_valid  output  1  high while a freshly fetched instruction is presented
- halted  output  1  high once HALT_OP has been issued
- pc  output  PC_W  current program counter

Behaviour:
- Reset (asynchronous, any state): state=IDLE, pc=0, opcode=0, mem_addr=0, imm_val=0, instr_valid=0, imem_csn=1, halted=0. imem_addr follows pc, so it resets to 0.
- FSM states: IDLE, REQ, WAIT, ISSUE, HALT. All outputs are registered or decoded from state only; no combinational path from inputs to outputs.
- IDLE: imem_csn=1. If run=1, go to REQ next edge.
- REQ: imem_csn=0, imem_addr=pc. Go to WAIT unconditionally.
- WAIT: imem_csn stays 0.
  - If imem_valid=1, latch imem_data into opcode/mem_addr/imm_val and go to ISSUE.
  - Otherwise remain in WAIT. There is no timeout.
- ISSUE: imem_csn=1, instr_valid=1.
  - If stall=1, remain in ISSUE; fields, pc and instr_valid are held.
  - If stall=0, leave on the next edge and resolve the next PC in this priority order:
    1. opcode==HALT_OP: go to HALT, pc unchanged, jmp_en ignored.
    2. jmp_en=1: pc<=jmp_addr.
    3. Otherwise pc<=pc+1, wrapping modulo 2^PC_W (all ones -> 0).
  - Next state is REQ if run=1, else IDLE.
- HALT: halted=1, imem_csn=1, instr_valid=0. Fields keep the halt instruction. Exit only by reset.
- Outside ISSUE: instr_valid=0, and opcode/mem_addr/imm_val keep their last latched value so the decoder sees stable inputs.
- Latency: with imem_valid high in the first WAIT cycle, run-to-first-instr_valid is 3 edges. Steady-state throughput is 1 instruction per 3 cycles (REQ, WAIT, ISSUE).
- run falling mid-operation: the current REQ/WAIT/ISSUE sequence completes, then the FSM goes to IDLE. pc already holds the next address.
- jmp_en or stall outside ISSUE: ignored.
- imem_valid outside WAIT: ignored.
- Reset during WAIT: imem_csn returns to 1 asynchronously and the pending return is discarded.

Decomposition:
- Shared package (cpu_defs) holds:
  - opcode width 3 and field widths 4/4;
  - instruction bit positions for the opcode / mem_addr / imm_val slices;
  - HALT_OP constant;
  - FSM state encoding, 3-bit localparams.
- The decoder consumes the same field constants.
- One natural sub-module: pc_reg (PC_W counter with load/increment/hold and async active-low reset). The FSM and instruction register stay in instr_fetch.

Test Plan:
- Reset then run=1; memory returns 0x132 (op=1, mem=3, imm=2) with zero wait -> instr_valid first high 3 edges after run, opcode=1, mem_addr=3, imm_val=2, pc goes 0->1 on leaving ISSUE.
- Memory delays imem_valid 4 cycles -> imem_csn low for REQ plus 5 WAIT cycles, imem_addr stable, a single ISSUE, no duplicate instr_valid.
- stall=1 for 3 cycles during ISSUE at pc=2 -> instr_valid and fields held 4 cycles, pc stays 2, then pc=3.
- jmp_en=1, jmp_addr=9 during ISSUE at pc=4 -> next REQ addresses 9. Starting at pc=15 with no jump -> wraps to 0.
- Fetch word 0x700 (op=7) -> halted=1 after ISSUE, imem_csn stays 1 for 10 cycles, pc frozen. Only rstn clears halted.
- Assert rstn=0 mid-WAIT, off the clock edge -> imem_csn=1, instr_valid=0, pc=0 immediately. A late imem_valid after release is ignored.

Source files
------------

// File: rtl/cpu_defs.sv
// Shared instruction-format and fetch-FSM definitions used by instr_fetch and instr_decoder.
// Pure constants and typedefs; no timing or flow-control behaviour of its own.
package cpu_defs;

  localparam int OP_W    = 3;
  localparam int MA_W    = 4;
  localparam int IMM_W   = 4;
  localparam int INSTR_W = OP_W + MA_W + IMM_W;

  localparam int OP_LSB  = 8;
  localparam int MA_LSB  = 4;
  localparam int IMM_LSB = 0;

  localparam logic [OP_W-1:0] CPU_HALT_OP = 3'b111;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_REQ   = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_ISSUE = 3'd3;
  localparam logic [2:0] ST_HALT  = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_REQ   = ST_REQ,
    S_WAIT  = ST_WAIT,
    S_ISSUE = ST_ISSUE,
    S_HALT  = ST_HALT
  } fetch_state_t;

  function automatic logic [OP_W-1:0] instr_op(input logic [INSTR_W-1:0] w);
    return w[OP_LSB +: OP_W];
  endfunction

  function automatic logic [MA_W-1:0] instr_ma(input logic [INSTR_W-1:0] w);
    return w[MA_LSB +: MA_W];
  endfunction

  function automatic logic [IMM_W-1:0] instr_imm(input logic [INSTR_W-1:0] w);
    return w[IMM_LSB +: IMM_W];
  endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter with load / increment / hold; updates one edge after the request.
// No backpressure: the owner simply deasserts load and inc to hold.
module pc_reg #(
  parameter int PC_W = 4
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            load,
  input  logic            inc,
  input  logic [PC_W-1:0] load_val,
  output logic [PC_W-1:0] pc
);

  // Load beats increment; increment wraps naturally at 2^PC_W.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc <= '0;
    end else if (load) begin
      pc <= load_val;
    end else if (inc) begin
      pc <= pc + PC_W'(1);
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: REQ/WAIT/ISSUE loop, one instruction per 3 cycles, first instr_valid 3 edges after run.
// stall holds ISSUE (fields, pc, instr_valid); memory may stretch WAIT indefinitely via imem_valid.
module instr_fetch
  import cpu_defs::*;
#(
  parameter int              PC_W    = 4,
  parameter logic [OP_W-1:0] HALT_OP = CPU_HALT_OP
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               run,
  output logic [PC_W-1:0]    imem_addr,
  output logic               imem_csn,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               imem_valid,
  input  logic               stall,
  input  logic               jmp_en,
  input  logic [PC_W-1:0]    jmp_addr,
  output logic [OP_W-1:0]    opcode,
  output logic [MA_W-1:0]    mem_addr,
  output logic [IMM_W-1:0]   imm_val,
  output logic               instr_valid,
  output logic               halted,
  output logic [PC_W-1:0]    pc
);

  fetch_state_t state;

  logic leave_issue;
  logic is_halt;
  logic pc_load;
  logic pc_inc;

  assign leave_issue = (state == S_ISSUE) && !stall;
  assign is_halt     = (opcode == HALT_OP);
  assign pc_load     = leave_issue && !is_halt && jmp_en;
  assign pc_inc      = leave_issue && !is_halt && !jmp_en;
  assign imem_addr   = pc;

  pc_reg #(.PC_W(PC_W)) u_pc_reg (
    .clk      (clk),
    .rstn     (rstn),
    .load     (pc_load),
    .inc      (pc_inc),
    .load_val (jmp_addr),
    .pc       (pc)
  );

  // Outputs are set on the transition into each state so they stay purely registered.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= S_IDLE;
      imem_csn    <= 1'b1;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
      opcode      <= '0;
      mem_addr    <= '0;
      imm_val     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (run) begin
            state    <= S_REQ;
            imem_csn <= 1'b0;
          end
        end
        S_REQ: begin
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (imem_valid) begin
            state       <= S_ISSUE;
            imem_csn    <= 1'b1;
            instr_valid <= 1'b1;
            opcode      <= instr_op(imem_data);
            mem_addr    <= instr_ma(imem_data);
            imm_val     <= instr_imm(imem_data);
          end
        end
        S_ISSUE: begin
          if (!stall) begin
            instr_valid <= 1'b0;
            if (is_halt) begin
              state  <= S_HALT;
              halted <= 1'b1;
            end else if (run) begin
              state    <= S_REQ;
              imem_csn <= 1'b0;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        S_HALT: begin
          state <= S_HALT;
        end
        default: begin
          state    <= S_IDLE;
          imem_csn <= 1'b1;
        end
      endcase
    end
  end

endmodule
